// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: round-robin front end for a single-port write-first RAM.
// Write and read request channels share the RAM port one operation per
// cycle; read data returns in issue order through a 2-entry response FIFO.
module sp_ram_arbiter #(
    parameter int DW    = 8,
    parameter int WORDS = 256,
    localparam int AW   = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_qout
);

    // Arbitration and read-return state
    logic          last_gnt_reg;   // 0 = write granted last, 1 = read
    logic          pend_reg;       // read issued last cycle, data on ram_qout now
    logic [1:0]    cnt_reg;        // buffered responses, 0..2
    logic          head_reg;       // FIFO read slot
    logic          tail_reg;       // FIFO write slot
    logic [DW-1:0] fifo_mem [2];

    logic          pop;
    logic          push;
    logic [2:0]    occ;
    logic          w_elig;
    logic          r_elig;
    logic          gnt_w;
    logic          gnt_r;

    assign pop  = (cnt_reg != 2'd0) && rsp_ready;
    assign push = pend_reg;

    // Slots committed after this edge: buffered plus in flight, minus the
    // one leaving now. Counting the pop lets a full buffer keep streaming
    // reads under rsp_ready, which is why rsp_ready reaches rd_ready
    // combinationally. pop implies cnt_reg >= 1, so this never underflows.
    assign occ    = {1'b0, cnt_reg} + {2'b00, pend_reg} - {2'b00, pop};
    assign w_elig = wr_valid;
    assign r_elig = rd_valid && (occ < 3'd2);

    // Grant: single eligible channel wins; on contention alternate away from last grant
    always_comb begin
        gnt_w = 1'b0;
        gnt_r = 1'b0;
        if (rst_n) begin
            if (w_elig && r_elig) begin
                gnt_w = last_gnt_reg;
                gnt_r = !last_gnt_reg;
            end else begin
                gnt_w = w_elig;
                gnt_r = r_elig;
            end
        end
    end

    assign wr_ready = gnt_w;
    assign rd_ready = gnt_r;
    assign ram_we   = gnt_w;
    assign ram_addr = gnt_w ? wr_addr : rd_addr;
    assign ram_din  = wr_data;

    // Control state: grant history, in-flight read flag and FIFO occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_reg <= 1'b1;
            pend_reg     <= 1'b0;
            cnt_reg      <= 2'd0;
            head_reg     <= 1'b0;
            tail_reg     <= 1'b0;
        end else begin
            if (gnt_w || gnt_r) begin
                last_gnt_reg <= gnt_r;
            end
            pend_reg <= gnt_r;
            if (push && !pop) begin
                cnt_reg <= cnt_reg + 2'd1;
            end else if (pop && !push) begin
                cnt_reg <= cnt_reg - 2'd1;
            end
            if (push) begin
                tail_reg <= ~tail_reg;
            end
            if (pop) begin
                head_reg <= ~head_reg;
            end
        end
    end

    // Response storage: capture RAM read data only in the cycle after a read
    // grant, so write-first echoes of din are never buffered
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[tail_reg] <= ram_qout;
        end
    end

    assign rsp_valid = (cnt_reg != 2'd0);
    assign rsp_data  = fifo_mem[head_reg];

    // The eligibility rule must make a push into a full, unpopped buffer impossible
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (cnt_reg == 2'd2) && !pop));

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: directed stimulus against a behavioural
// write-first RAM, with a scoreboard queue checked by a forked monitor.
module tb_sp_ram_arbiter;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_addr;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_din;
    logic [7:0] ram_qout;

    logic [7:0] mem [256];
    logic [7:0] exp_q [$];
    int         n_vec;
    int         n_err;

    sp_ram_arbiter #(.DW(8), .WORDS(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_qout  (ram_qout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first single-port RAM with registered output
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            ram_qout      <= ram_din;
        end else begin
            ram_qout <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", name, act, req, $time);
        end else begin
            $display("ok   %s: 0x%0h @%0t", name, act, $time);
        end
    endtask

    // Response monitor: pops the scoreboard on each handshake and checks hold stability
    task automatic monitor();
        logic       hold;
        logic [7:0] held;
        logic [7:0] e;
        hold = 1'b0;
        held = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (hold && rsp_valid) begin
                    check("rsp_hold", 32'(rsp_data), 32'(held));
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 32'(rsp_valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_data", 32'(rsp_data), 32'(e));
                    end
                end
                hold = rsp_valid && !rsp_ready;
                held = rsp_data;
            end else begin
                hold = 1'b0;
            end
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        int t;
        t = 0;
        @(posedge clk); #1;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(negedge clk);
        while (!wr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("wr_handshake", 32'(wr_ready), 1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int acc;
        int cnt_a;
        int cnt_b;
        int t;
        logic [7:0] bp_addr;

        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        wr_valid  = 1'b1;
        rd_valid  = 1'b1;
        wr_addr   = 8'h00;
        wr_data   = 8'h00;
        rd_addr   = 8'h00;
        rsp_ready = 1'b1;
        fork
            monitor();
        join_none

        // Reset with both requests asserted: nothing may be granted
        repeat (3) @(negedge clk);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_rd_ready", 32'(rd_ready), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        rst_n    = 1'b1;

        // Contention: grants alternate W,R,... starting with W; each read
        // targets the address just written
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            wr_valid = 1'b1;
            rd_valid = 1'b1;
            wr_addr  = 8'(32'h20 + k / 2);
            wr_data  = 8'(32'hC0 + k);
            rd_addr  = 8'(32'h20 + k / 2);
            @(negedge clk);
            check("cont_grant_wr_rd", 32'({wr_ready, rd_ready}), (k % 2 == 0) ? 32'h2 : 32'h1);
            if (rd_ready) begin
                exp_q.push_back(8'(32'hC0 + k - 1));
            end
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("cont_drain", 32'(exp_q.size()), 0);

        // Write then read: 2-cycle read latency and new data returned
        do_write(8'h03, 8'hA5);
        @(posedge clk); #1;
        rd_valid = 1'b1;
        rd_addr  = 8'h03;
        @(negedge clk);
        check("wr_rd_handshake", 32'(rd_ready), 1);
        if (rd_ready) exp_q.push_back(8'hA5);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        check("lat_cycle2_valid", 32'(rsp_valid), 1);

        // Preload 0..15 with addr ^ 0x5A
        for (int i = 0; i < 16; i++) begin
            do_write(8'(i), 8'(i) ^ 8'h5A);
        end

        // Streaming reads: one accept and one response per cycle, no bubbles
        acc   = 0;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            rd_valid = (i < 16);
            rd_addr  = 8'(i);
            @(negedge clk);
            if (i < 16 && rd_ready) begin
                acc++;
                exp_q.push_back(8'(i) ^ 8'h5A);
            end
            if (i < 2 && rsp_valid) cnt_a++;
            if (i >= 2 && rsp_valid) cnt_b++;
        end
        check("stream_accepted", 32'(acc), 16);
        check("stream_early_valid", 32'(cnt_a), 0);
        check("stream_valid_cycles", 32'(cnt_b), 16);
        check("stream_drain", 32'(exp_q.size()), 0);

        // Back-pressure: exactly two reads accepted, then stall
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        bp_addr   = 8'd4;
        acc       = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            rd_valid = 1'b1;
            rd_addr  = bp_addr;
            @(negedge clk);
            if (rd_ready) begin
                exp_q.push_back(bp_addr ^ 8'h5A);
                acc++;
                bp_addr++;
            end
        end
        check("bp_accepted", 32'(acc), 2);
        check("bp_rd_ready", 32'(rd_ready), 0);
        check("bp_rsp_valid", 32'(rsp_valid), 1);

        // Release back-pressure: drain in order and resume at one read per cycle
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            rd_addr   = bp_addr;
            @(negedge clk);
            if (rd_ready) begin
                exp_q.push_back(bp_addr ^ 8'h5A);
                acc++;
                bp_addr++;
            end
        end
        check("bp_resume_accepted", 32'(acc), 4);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("bp_drain", 32'(exp_q.size()), 0);

        // Fill the buffer, then reset mid-stream
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            rd_valid = 1'b1;
            rd_addr  = 8'(32'd10 + i);
            @(negedge clk);
            if (rd_ready) exp_q.push_back(8'(32'd10 + i) ^ 8'h5A);
        end
        check("full_rsp_valid", 32'(rsp_valid), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_rsp_valid", 32'(rsp_valid), 0);
        exp_q.delete();
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) cnt_a++;
        end
        check("no_stale_rsp", 32'(cnt_a), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
